// File: rtl/cache_mem_arb_pkg.sv
// Shared types for the I/D cache memory-port arbiter.
package cache_mem_arb_pkg;

  localparam int unsigned DefaultLineBeats = 8;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StRdata,
    StWdata
  } state_e;

  typedef enum logic {
    OwnerI = 1'b0,
    OwnerD = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin picker; bit 0 = I-cache, bit 1 = D-cache.
module mem_arb_rr2
  import cache_mem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] gnt_o
);

  owner_e last_q, last_d;

  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      // Tie goes to whoever did not win last time.
      2'b11:   gnt_o = (last_q == OwnerD) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
    if (update_i && (gnt_o != 2'b00)) begin
      last_d = gnt_o[1] ? OwnerD : OwnerI;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= OwnerD;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one line-burst memory port between I-cache refills and D-cache refills/writebacks.
module cache_mem_arbiter
  import cache_mem_arb_pkg::*;
#(
  parameter int unsigned LINE_BEATS = DefaultLineBeats,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_ireq_valid,
  output logic                  io_ireq_ready,
  input  logic [ADDR_WIDTH-1:0] io_ireq_addr,
  input  logic                  io_iflush,
  output logic                  io_irsp_valid,
  output logic                  io_irsp_last,
  output logic [31:0]           io_irsp_data,
  input  logic                  io_dreq_valid,
  output logic                  io_dreq_ready,
  input  logic [ADDR_WIDTH-1:0] io_dreq_addr,
  input  logic                  io_dreq_write,
  input  logic [31:0]           io_dwdata,
  output logic                  io_dwdata_ready,
  output logic                  io_drsp_valid,
  output logic                  io_drsp_last,
  output logic [31:0]           io_drsp_data,
  output logic                  io_mem_req_valid,
  input  logic                  io_mem_req_ready,
  output logic [ADDR_WIDTH-1:0] io_mem_req_addr,
  output logic                  io_mem_req_write,
  output logic                  io_mem_wvalid,
  input  logic                  io_mem_wready,
  output logic                  io_mem_wlast,
  output logic [31:0]           io_mem_wdata,
  input  logic                  io_mem_rvalid,
  input  logic                  io_mem_rlast,
  input  logic [31:0]           io_mem_rdata
);

  localparam int unsigned CntW = $clog2(LINE_BEATS);
  localparam logic [CntW-1:0] LastBeat = CntW'(LINE_BEATS - 1);

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  drop_q, drop_d;
  logic [1:0]            elig, gnt;
  logic                  flush_hit, drop_now;

  // Nothing is granted while reset is held so every ready stays low.
  assign elig = {io_dreq_valid, io_ireq_valid & ~io_iflush} & {2{~reset}};

  mem_arb_rr2 u_rr2 (
    .clk_i    (clock),
    .rst_i    (reset),
    .req_i    (elig),
    .update_i (state_q == StIdle),
    .gnt_o    (gnt)
  );

  assign flush_hit = io_iflush && (owner_q == OwnerI) &&
                     ((state_q == StReq) || (state_q == StRdata));
  assign drop_now  = drop_q | flush_hit;

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    addr_d           = addr_q;
    write_d          = write_q;
    cnt_d            = cnt_q;
    drop_d           = drop_now;
    io_ireq_ready    = 1'b0;
    io_dreq_ready    = 1'b0;
    io_irsp_valid    = 1'b0;
    io_irsp_last     = 1'b0;
    io_irsp_data     = io_mem_rdata;
    io_drsp_valid    = 1'b0;
    io_drsp_last     = 1'b0;
    io_drsp_data     = io_mem_rdata;
    io_dwdata_ready  = 1'b0;
    io_mem_req_valid = 1'b0;
    io_mem_req_addr  = addr_q;
    io_mem_req_write = write_q;
    io_mem_wvalid    = 1'b0;
    io_mem_wlast     = 1'b0;
    io_mem_wdata     = io_dwdata;

    unique case (state_q)
      StIdle: begin
        io_ireq_ready = gnt[0];
        io_dreq_ready = gnt[1];
        if (gnt != 2'b00) begin
          owner_d = gnt[1] ? OwnerD : OwnerI;
          addr_d  = gnt[1] ? io_dreq_addr : io_ireq_addr;
          write_d = gnt[1] & io_dreq_write;
          state_d = StReq;
        end
      end
      StReq: begin
        io_mem_req_valid = 1'b1;
        if (io_mem_req_ready) begin
          cnt_d   = '0;
          state_d = write_q ? StWdata : StRdata;
        end
      end
      StRdata: begin
        if (io_mem_rvalid) begin
          cnt_d = cnt_q + 1'b1;
          if (owner_q == OwnerD) begin
            io_drsp_valid = 1'b1;
            io_drsp_last  = io_mem_rlast;
          end else if (!drop_now) begin
            io_irsp_valid = 1'b1;
            io_irsp_last  = io_mem_rlast;
          end
          if (io_mem_rlast) state_d = StIdle;
        end
      end
      StWdata: begin
        io_mem_wvalid   = 1'b1;
        io_mem_wlast    = (cnt_q == LastBeat);
        io_dwdata_ready = io_mem_wready;
        if (io_mem_wready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastBeat) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StIdle) drop_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      owner_q <= OwnerI;
      addr_q  <= '0;
      write_q <= 1'b0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single refill/writeback memory port between the instruction cache (read-only line refills) and the data cache (line refills and dirty-line writebacks). Sits between both cache MSHRs and the memory model / bus bridge. Grants one whole line burst at a time with 2-way round-robin arbitration. Drops refill beats for an instruction burst cancelled by an I-cache flush, without aborting the memory transaction.

## Interface
- LINE_BEATS, 8, 32-bit beats per cache line (power of two, ≥2)
- ADDR_WIDTH, 32, byte address width
- clock  in  1  single clock; everything is sampled on its rising edge
- reset  in  1  synchronous, active-high
- io_ireq_valid / io_ireq_ready  in/out  1  I-cache line request handshake
- io_ireq_addr  in  ADDR_WIDTH  line-aligned refill address
- io_iflush  in  1  I-cache flush; cancels the pending or in-flight I burst
- io_irsp_valid / io_irsp_last  out  1  refill beat valid, final beat
- io_irsp_data  out  32  refill beat
- io_dreq_valid / io_dreq_ready  in/out  1  D-cache line request handshake
- io_dreq_addr  in  ADDR_WIDTH  line-aligned address
- io_dreq_write  in  1  1 = writeback, 0 = refill
- io_dwdata  in  32  current writeback beat
- io_dwdata_ready  out  1  current writeback beat consumed; D-cache advances
- io_drsp_valid / io_drsp_last / io_drsp_data  out  1/1/32  D refill beats
- io_mem_req_valid / io_mem_req_ready  out/in  1  memory burst request
- io_mem_req_addr / io_mem_req_write  out  ADDR_WIDTH/1  latched address and direction
- io_mem_wvalid / io_mem_wready / io_mem_wlast  out/in/out  1  write beat channel
- io_mem_wdata  out  32  write beat
- io_mem_rvalid / io_mem_rlast / io_mem_rdata  in  1/1/32  read beat channel

## Operation
- FSM states: IDLE, REQ, RDATA, WDATA. Registers: owner (I/D), last_grant, addr, write, beat_cnt (log2 LINE_BEATS bits), drop.
- IDLE, arbitration:
  - A requester is eligible when its valid is high. I is not eligible in a cycle with io_iflush high.
  - One eligible requester: it wins. Both eligible: the one not equal to last_grant wins.
  - Winner's ready = 1 for that cycle only (combinational). Latch addr, write (I forces 0), owner. Update last_grant. Go to REQ.
- REQ: io_mem_req_valid = 1 with latched addr/write until io_mem_req_ready. Then go to WDATA if write=1, else RDATA. beat_cnt = 0.
- RDATA:
  - Each io_mem_rvalid beat is forwarded combinationally to the owner's rsp_valid/data/last, with last = io_mem_rlast. beat_cnt increments.
  - On a beat with rlast, go to IDLE.
  - Responses have no backpressure; the caches always accept refill beats.
- WDATA:
  - io_mem_wvalid = 1, io_mem_wdata = io_dwdata, io_dwdata_ready = io_mem_wready.
  - io_mem_wlast = (beat_cnt == LINE_BEATS-1).
  - After the last beat is accepted, go to IDLE.
- Flush:
  - io_iflush high while owner=I in REQ or RDATA sets drop. io_irsp_valid is forced 0 from that same cycle until the burst ends.
  - The burst still completes on the memory side. drop clears on return to IDLE.
  - Flush never affects D transfers.
- beat_cnt wraps modulo LINE_BEATS. A read burst ends only on rlast.

## Timing
- Reset values:
  - state = IDLE, last_grant = D (I wins the first tie), drop = 0, beat_cnt = 0, addr = 0.
  - Every valid, ready, and last output is 0.
- Grant to io_mem_req_valid: 1 cycle. There is no idle gap between consecutive bursts beyond the one IDLE cycle.
- Read beat latency through the block: 0 cycles, combinational.
- Reset mid-burst: the block returns to IDLE next cycle. Memory and caches share the reset.
- Simultaneous io_iflush and io_ireq_valid in IDLE: I is not granted. D may be granted.

## Structure
- Package cache_mem_arb_pkg: state enum, owner enum, default LINE_BEATS.
- Sub-module mem_arb_rr2: the 2-way round-robin picker, holding last_grant internally with an update-enable input.

## Test plan
- Both requesters valid from reset, both read; D at 0x100, I at 0x200. Required: I granted first. After its 8 beats with rlast on beat 8, D is granted. Next tie goes to I.
- D writeback to 0x40 with io_mem_wready toggling 1,0,1,... Required: exactly 8 io_dwdata_ready pulses and wlast only on the 8th accepted beat, then IDLE.
- I refill, io_iflush on the 3rd rvalid beat. Required: io_irsp_valid seen for beats 1-2 only. The memory burst still completes. The next I request is granted normally.
- io_iflush and io_ireq_valid high together in IDLE with D idle. Required: io_ireq_ready = 0. Grant happens the next cycle once flush is low.
- io_mem_req_ready held low for 5 cycles. Required: io_mem_req_valid, addr, and write stay stable. No rsp_valid.
- reset asserted mid-RDATA at beat 4. Required: all outputs 0 the next cycle and state IDLE. A new request is granted normally afterwards.
